// File: rtl/hex_scan_display.sv
// Time-multiplexed hex driver for a shared active-low seven-segment bus.
// Scans captured nibbles round-robin with leading-zero blanking and blink.
module hex_scan_display #(
   parameter int DIGITS       = 4,
   parameter int DIV          = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic                  lz_en,
   input  logic [DIGITS-1:0]     blink_en,
   output logic [0:6]            display,
   output logic [DIGITS-1:0]     an
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [4*DIGITS-1:0] shadow;
   logic [PW-1:0]       presc;
   logic [IW-1:0]       idx;
   logic [FW-1:0]       fcnt;
   logic                phase;

   logic                tick;
   logic                last;
   logic                wrap;
   logic [3:0]          nib;
   logic [6:0]          seg;
   logic                blank;
   logic [DIGITS-1:0]   zero_above;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0001100;
         4'ha: s = 7'b0001000;
         4'hb: s = 7'b1100000;
         4'hc: s = 7'b0110001;
         4'hd: s = 7'b1000010;
         4'he: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // zero_above[i]: nibbles i..DIGITS-1 are all zero
   always_comb begin
      zero_above = '0;
      zero_above[DIGITS-1] = (shadow[4*DIGITS-1 -: 4] == 4'h0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         zero_above[i] = zero_above[i+1] && (shadow[4*i +: 4] == 4'h0);
      end
   end

   assign tick  = (presc == PW'(DIV - 1));
   assign last  = (idx == IW'(DIGITS - 1));
   assign wrap  = tick && last;
   assign nib   = shadow[4*int'(idx) +: 4];
   assign seg   = decode(nib);
   assign blank = (lz_en && (idx != '0) && zero_above[idx])
               || (blink_en[idx] && phase);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shadow  <= '0;
         presc   <= '0;
         idx     <= '0;
         fcnt    <= '0;
         phase   <= 1'b0;
         display <= 7'b1111111;
         an      <= '1;
      end else begin
         if (load) shadow <= value;
         presc <= tick ? '0 : presc + PW'(1);
         if (tick) idx <= last ? '0 : idx + IW'(1);
         if (wrap) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
               fcnt  <= '0;
               phase <= ~phase;
            end else begin
               fcnt <= fcnt + FW'(1);
            end
         end
         display <= blank ? 7'b1111111 : seg;
         an      <= blank ? '1 : ~(DIGITS'(1) << idx);
      end
   end

endmodule
